// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-stream traffic generator.
// Holds the FSM state encoding, the LFSR feedback mask and the LFSR step function.
// No logic of its own; imported by the generator top and the LFSR sub-module.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Galois feedback taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // One right-shift Galois step
  function automatic logic [31:0] lfsr_next(input logic [31:0] p);
    return (p >> 1) ^ (p[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/axis_lfsr32.sv
// 32-bit Galois LFSR with load and advance; a zero seed loads as 1 so the sequence never locks up.
// Latency: new state visible the cycle after load/advance.
// Backpressure: none internally; the caller only pulses advance on a handshake.
module axis_lfsr32
  import axis_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] r_state;

  // Load takes priority over advance; all-zero is never a legal running state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= 32'h0;
    end else if (load) begin
      r_state <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-stream burst source: emits burst_len beats of incrementing or LFSR data with optional idle gaps.
// Latency: first beat valid the cycle after an accepted start; done pulses the cycle after the last handshake.
// Backpressure: holds m_valid/m_data/m_last stable while m_ready is low; m_valid never depends on m_ready.
module axis_traffic_gen
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  pattern_sel,
  input  logic [31:0]           seed,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  state_t               r_state;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_done;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] r_len;
  logic [GAP_WIDTH-1:0] r_gap;
  logic [GAP_WIDTH-1:0] r_gcnt;
  logic                 r_sel;
  logic [31:0]          r_inc;

  state_t               w_state_nxt;
  logic                 w_valid_nxt;
  logic                 w_last_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [LEN_WIDTH-1:0] w_cnt_nxt;
  logic [LEN_WIDTH-1:0] w_len_nxt;
  logic [GAP_WIDTH-1:0] w_gap_nxt;
  logic [GAP_WIDTH-1:0] w_gcnt_nxt;
  logic                 w_sel_nxt;
  logic [31:0]          w_inc_nxt;
  logic                 w_lfsr_load;
  logic                 w_lfsr_adv;
  logic [31:0]          w_lfsr_state;
  logic [31:0]          w_pattern;

  axis_lfsr32 u_lfsr (
    .clk     (aclk),
    .rst     (areset),
    .load    (w_lfsr_load),
    .seed    (seed),
    .advance (w_lfsr_adv),
    .state   (w_lfsr_state)
  );

  // State and registered outputs; synchronous reset aborts any burst without a done pulse
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_sel   <= 1'b0;
      r_inc   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_gap   <= w_gap_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_sel   <= w_sel_nxt;
      r_inc   <= w_inc_nxt;
    end
  end

  // Next-state and next-output decode; m_last is precomputed so it leaves a flop
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_gap_nxt   = r_gap;
    w_gcnt_nxt  = r_gcnt;
    w_sel_nxt   = r_sel;
    w_inc_nxt   = r_inc;
    w_lfsr_load = 1'b0;
    w_lfsr_adv  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_cnt_nxt = '0;
          if (burst_len != '0) begin
            w_len_nxt   = burst_len;
            w_gap_nxt   = gap;
            w_sel_nxt   = pattern_sel;
            w_inc_nxt   = seed;
            w_lfsr_load = 1'b1;
            w_busy_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (burst_len == LEN_WIDTH'(1));
            w_state_nxt = SEND;
          end else begin
            // Empty burst completes immediately
            w_done_nxt = 1'b1;
          end
        end
      end

      SEND: begin
        if (r_valid && m_ready) begin
          w_cnt_nxt  = r_cnt + LEN_WIDTH'(1);
          w_inc_nxt  = r_inc + 32'h1;
          w_lfsr_adv = r_sel;
          if (r_last) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (r_gap != '0) begin
            w_state_nxt = GAP;
            w_gcnt_nxt  = r_gap;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            w_last_nxt = (w_cnt_nxt == (r_len - LEN_WIDTH'(1)));
          end
        end
      end

      GAP: begin
        // gcnt counts the remaining idle cycles including the current one
        w_gcnt_nxt = r_gcnt - GAP_WIDTH'(1);
        if (r_gcnt == GAP_WIDTH'(1)) begin
          w_state_nxt = SEND;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (r_cnt == (r_len - LEN_WIDTH'(1)));
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign w_pattern = r_sel ? w_lfsr_state : r_inc;

  assign m_data   = w_pattern[DATA_WIDTH-1:0];
  assign m_valid  = r_valid;
  assign m_last   = r_last;
  assign busy     = r_busy;
  assign done     = r_done;
  assign beat_cnt = r_cnt;

endmodule
